outputs_workload_dispatcher: RTL and testbench

Sequencing controller that takes one workload descriptor {id, size} at a time from the upstream chiplet stage and dispatches per-output shares to num_out_p downstream channels. Each channel has its own valid/ready handshake. The block then collects a completion pulse from every channel that received a share, and emits one completion for the whole workload. It sits between the chiplet's input workload queue and its output links, replacing a purely combinational fan-out with a handshaked, completion-tracked one.

---
 rtl/outputs_workload_dispatcher_pkg.sv | 14 +
 rtl/outputs_workload_dispatcher_share_calc.sv | 32 +++
 rtl/outputs_workload_dispatcher.sv | 134 +++++++++++++
 tb/tb_outputs_workload_dispatcher.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/outputs_workload_dispatcher_pkg.sv
// Shared definitions for the workload dispatcher: output-mode constants and FSM states.
package outputs_workload_pkg;

    localparam int e_outputs_replicate = 0;
    localparam int e_outputs_split     = 1;

    typedef enum logic [1:0] {
        e_idle,
        e_dispatch,
        e_wait_done,
        e_done
    } dispatch_state_e;

endpackage

// File: rtl/outputs_workload_dispatcher_share_calc.sv
// Combinational per-output share computation: replicate the size, or split it with the
// remainder going to the lowest-index outputs.
module workload_share_calc
    import outputs_workload_pkg::*;
#(
    parameter int size_width_p     = 16,
    parameter int num_out_p        = 4,
    parameter int outputs_config_p = e_outputs_split
) (
    input  logic [size_width_p-1:0]                size_i,
    output logic [num_out_p-1:0][size_width_p-1:0] share_o
);

    localparam logic [size_width_p-1:0] div_c = size_width_p'(num_out_p);

    logic [size_width_p-1:0] quot;
    logic [size_width_p-1:0] rem;

    always_comb begin
        quot    = size_i / div_c;
        rem     = size_i % div_c;
        share_o = '0;
        for (int i = 0; i < num_out_p; i++) begin
            if (outputs_config_p == e_outputs_replicate || num_out_p == 1) begin
                share_o[i] = size_i;
            end else begin
                share_o[i] = quot + ((size_width_p'(i) < rem) ? size_width_p'(1) : '0);
            end
        end
    end

endmodule

// File: rtl/outputs_workload_dispatcher.sv
// Accepts one {id, size} descriptor, hands a share to each output over valid/ready,
// then collects per-output completions and reports one completion for the workload.
//
// state       | meaning
// e_idle      | ready_o high, waiting for a descriptor
// e_dispatch  | presenting shares on outputs still in send_mask
// e_wait_done | all shares handed off, waiting for pend_mask to drain
// e_done      | one-cycle done_v_o with done_id_o
module outputs_workload_dispatcher
    import outputs_workload_pkg::*;
#(
    parameter int id_width_p       = 8,
    parameter int size_width_p     = 16,
    parameter int num_out_p        = 4,
    parameter int outputs_config_p = e_outputs_split,
    parameter int width_p          = id_width_p + size_width_p
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              v_i,
    input  logic [width_p-1:0]                data_i,
    output logic                              ready_o,
    output logic [num_out_p-1:0]              v_o,
    output logic [num_out_p-1:0][width_p-1:0] data_o,
    input  logic [num_out_p-1:0]              ready_i,
    input  logic [num_out_p-1:0]              done_v_i,
    output logic                              done_v_o,
    output logic [id_width_p-1:0]             done_id_o
);

    if (outputs_config_p != e_outputs_replicate && outputs_config_p != e_outputs_split) begin : g_bad_config
        $error("outputs_config_p must be 0 (replicate) or 1 (split)");
    end

    typedef struct packed {
        logic [id_width_p-1:0]   id;
        logic [size_width_p-1:0] size;
    } desc_t;

    desc_t                                 desc_in;
    dispatch_state_e                       state;
    logic [id_width_p-1:0]                 id_r;
    logic [num_out_p-1:0][size_width_p-1:0] share_c;
    logic [num_out_p-1:0][size_width_p-1:0] share_r;
    logic [num_out_p-1:0]                  send_mask;
    logic [num_out_p-1:0]                  pend_mask;
    logic [num_out_p-1:0]                  send_init;
    logic [num_out_p-1:0]                  send_next;
    logic [num_out_p-1:0]                  pend_next;

    assign desc_in = desc_t'(data_i);

    workload_share_calc #(
        .size_width_p     (size_width_p),
        .num_out_p        (num_out_p),
        .outputs_config_p (outputs_config_p)
    ) u_share_calc (
        .size_i  (desc_in.size),
        .share_o (share_c)
    );

    always_comb begin
        send_init = '0;
        for (int i = 0; i < num_out_p; i++) begin
            send_init[i] = (share_c[i] != '0);
        end
    end

    // A done only counts against a bit already pending, so a same-cycle handshake wins.
    assign send_next = send_mask & ~ready_i;
    assign pend_next = (pend_mask & ~done_v_i) | (send_mask & ready_i);

    assign v_o = send_mask;

    always_comb begin
        data_o = '0;
        for (int i = 0; i < num_out_p; i++) begin
            data_o[i] = {id_r, share_r[i]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state     <= e_idle;
            id_r      <= '0;
            share_r   <= '0;
            send_mask <= '0;
            pend_mask <= '0;
            ready_o   <= 1'b1;
            done_v_o  <= 1'b0;
            done_id_o <= '0;
        end else begin
            done_v_o <= 1'b0;
            case (state)
                e_idle: begin
                    if (v_i && ready_o) begin
                        id_r      <= desc_in.id;
                        share_r   <= share_c;
                        send_mask <= send_init;
                        pend_mask <= '0;
                        ready_o   <= 1'b0;
                        if (send_init == '0) begin
                            state     <= e_done;
                            done_v_o  <= 1'b1;
                            done_id_o <= desc_in.id;
                        end else begin
                            state <= e_dispatch;
                        end
                    end
                end
                e_dispatch, e_wait_done: begin
                    send_mask <= send_next;
                    pend_mask <= pend_next;
                    if (send_next == '0 && pend_next == '0) begin
                        state     <= e_done;
                        done_v_o  <= 1'b1;
                        done_id_o <= id_r;
                    end else if (send_next == '0) begin
                        state <= e_wait_done;
                    end
                end
                e_done: begin
                    state   <= e_idle;
                    ready_o <= 1'b1;
                end
                default: begin
                    state   <= e_idle;
                    ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_outputs_workload_dispatcher.sv
// Scoreboard bench: a split/4-output instance and a replicate/3-output instance driven
// by directed vectors; a negedge monitor pops expected handshakes and completions.
module tb_outputs_workload_dispatcher;

    logic clk = 1'b0;
    logic reset_i;
    always #5 clk = ~clk;

    // split instance, 4 outputs
    logic             s_v_i;
    logic [15:0]      s_data_i;
    logic             s_ready_o;
    logic [3:0]       s_v_o;
    logic [3:0][15:0] s_data_o;
    logic [3:0]       s_ready_i;
    logic [3:0]       s_done_v_i;
    logic             s_done_v_o;
    logic [7:0]       s_done_id_o;

    // replicate instance, 3 outputs
    logic             r_v_i;
    logic [15:0]      r_data_i;
    logic             r_ready_o;
    logic [2:0]       r_v_o;
    logic [2:0][15:0] r_data_o;
    logic [2:0]       r_ready_i;
    logic [2:0]       r_done_v_i;
    logic             r_done_v_o;
    logic [7:0]       r_done_id_o;

    outputs_workload_dispatcher #(
        .id_width_p(8), .size_width_p(8), .num_out_p(4), .outputs_config_p(1)
    ) dut_s (
        .clk_i(clk), .reset_i(reset_i), .v_i(s_v_i), .data_i(s_data_i), .ready_o(s_ready_o),
        .v_o(s_v_o), .data_o(s_data_o), .ready_i(s_ready_i), .done_v_i(s_done_v_i),
        .done_v_o(s_done_v_o), .done_id_o(s_done_id_o)
    );

    outputs_workload_dispatcher #(
        .id_width_p(8), .size_width_p(8), .num_out_p(3), .outputs_config_p(0)
    ) dut_r (
        .clk_i(clk), .reset_i(reset_i), .v_i(r_v_i), .data_i(r_data_i), .ready_o(r_ready_o),
        .v_o(r_v_o), .data_o(r_data_o), .ready_i(r_ready_i), .done_v_i(r_done_v_i),
        .done_v_o(r_done_v_o), .done_id_o(r_done_id_o)
    );

    typedef struct {
        int          key;   // dut*8 + output index
        logic [15:0] data;
    } hs_t;

    hs_t        exp_q[$];
    logic [7:0] s_done_q[$];
    logic [7:0] r_done_q[$];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_hs(input int key, input logic [15:0] d);
        hs_t e;
        e.key  = key;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic hs_match(input int key, input logic [15:0] d);
        int found;
        found = -1;
        for (int k = 0; k < exp_q.size(); k++) begin
            if (found < 0 && exp_q[k].key == key) found = k;
        end
        if (found < 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL hs_unexpected key=%0d: got data %0h, expected no handshake (t=%0t)", key, d, $time);
        end else begin
            chk($sformatf("hs_data key=%0d", key), 32'(d), 32'(exp_q[found].data));
            exp_q.delete(found);
        end
    endtask

    logic [3:0]       s_prev_pend;
    logic [3:0][15:0] s_prev_data;
    logic [2:0]       r_prev_pend;
    logic [2:0][15:0] r_prev_data;

    always @(negedge clk) begin
        if (reset_i) begin
            s_prev_pend = '0;
            r_prev_pend = '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (s_prev_pend[i]) begin
                    chk($sformatf("s_hold_v%0d", i), 32'(s_v_o[i]), 32'd1);
                    chk($sformatf("s_hold_data%0d", i), 32'(s_data_o[i]), 32'(s_prev_data[i]));
                end
                if (s_v_o[i] && s_ready_i[i]) hs_match(i, s_data_o[i]);
            end
            for (int i = 0; i < 3; i++) begin
                if (r_prev_pend[i]) begin
                    chk($sformatf("r_hold_v%0d", i), 32'(r_v_o[i]), 32'd1);
                    chk($sformatf("r_hold_data%0d", i), 32'(r_data_o[i]), 32'(r_prev_data[i]));
                end
                if (r_v_o[i] && r_ready_i[i]) hs_match(8 + i, r_data_o[i]);
            end
            s_prev_pend = s_v_o & ~s_ready_i;
            s_prev_data = s_data_o;
            r_prev_pend = r_v_o & ~r_ready_i;
            r_prev_data = r_data_o;
            if (s_done_v_o) begin
                if (s_done_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL s_done_unexpected: got done id %0h, expected none (t=%0t)", s_done_id_o, $time);
                end else begin
                    chk("s_done_id", 32'(s_done_id_o), 32'(s_done_q.pop_front()));
                end
            end
            if (r_done_v_o) begin
                if (r_done_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL r_done_unexpected: got done id %0h, expected none (t=%0t)", r_done_id_o, $time);
                end else begin
                    chk("r_done_id", 32'(r_done_id_o), 32'(r_done_q.pop_front()));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_s(input logic [7:0] id, input logic [7:0] sz);
        chk("s_ready_before_accept", 32'(s_ready_o), 32'd1);
        s_v_i    = 1'b1;
        s_data_i = {id, sz};
        tick();
        s_v_i    = 1'b0;
        s_data_i = '0;
    endtask

    task automatic send_r(input logic [7:0] id, input logic [7:0] sz);
        chk("r_ready_before_accept", 32'(r_ready_o), 32'd1);
        r_v_i    = 1'b1;
        r_data_i = {id, sz};
        tick();
        r_v_i    = 1'b0;
        r_data_i = '0;
    endtask

    initial begin
        reset_i    = 1'b1;
        s_v_i      = 1'b0; s_data_i = '0; s_ready_i = '0; s_done_v_i = '0;
        r_v_i      = 1'b0; r_data_i = '0; r_ready_i = '0; r_done_v_i = '0;
        tick();
        tick();
        chk("rst_s_ready", 32'(s_ready_o), 32'd1);
        chk("rst_s_v_o", 32'(s_v_o), 32'd0);
        chk("rst_s_done_v", 32'(s_done_v_o), 32'd0);
        chk("rst_s_data_o", 32'(s_data_o[0] | s_data_o[1] | s_data_o[2] | s_data_o[3]), 32'd0);
        chk("rst_s_done_id", 32'(s_done_id_o), 32'd0);
        chk("rst_r_ready", 32'(r_ready_o), 32'd1);
        chk("rst_r_v_o", 32'(r_v_o), 32'd0);
        reset_i = 1'b0;
        tick();

        // split size=10 id=5: shares 3,3,2,2
        s_ready_i = 4'hf;
        push_hs(0, 16'h0503); push_hs(1, 16'h0503); push_hs(2, 16'h0502); push_hs(3, 16'h0502);
        s_done_q.push_back(8'h05);
        send_s(8'h05, 8'd10);
        chk("t1_v_o", 32'(s_v_o), 32'hf);
        chk("t1_data0", 32'(s_data_o[0]), 32'h0503);
        chk("t1_data3", 32'(s_data_o[3]), 32'h0502);
        chk("t1_ready_t1", 32'(s_ready_o), 32'd0);
        tick();
        chk("t1_v_o_t2", 32'(s_v_o), 32'h0);
        chk("t1_ready_t2", 32'(s_ready_o), 32'd0);
        chk("t1_done_t2", 32'(s_done_v_o), 32'd0);
        s_done_v_i = 4'hf;
        tick();
        s_done_v_i = '0;
        chk("t1_done_t3", 32'(s_done_v_o), 32'd1);
        chk("t1_ready_t3", 32'(s_ready_o), 32'd0);
        tick();
        chk("t1_ready_t4", 32'(s_ready_o), 32'd1);
        chk("t1_done_t4", 32'(s_done_v_o), 32'd0);

        // split size=2: only outputs 0,1; dones on 2,3 ignored
        push_hs(0, 16'h2101); push_hs(1, 16'h2101);
        s_done_q.push_back(8'h21);
        send_s(8'h21, 8'd2);
        chk("t2_v_o", 32'(s_v_o), 32'h3);
        tick();
        s_done_v_i = 4'b1100;
        tick();
        chk("t2_no_done", 32'(s_done_v_o), 32'd0);
        s_done_v_i = 4'b0011;
        tick();
        s_done_v_i = '0;
        chk("t2_done", 32'(s_done_v_o), 32'd1);
        tick();
        chk("t2_ready_back", 32'(s_ready_o), 32'd1);

        // split size=0: no output traffic, done right after acceptance
        s_done_q.push_back(8'h33);
        send_s(8'h33, 8'd0);
        chk("t3_v_o", 32'(s_v_o), 32'h0);
        chk("t3_done", 32'(s_done_v_o), 32'd1);
        chk("t3_ready", 32'(s_ready_o), 32'd0);
        tick();
        chk("t3_ready_back", 32'(s_ready_o), 32'd1);
        chk("t3_done_gone", 32'(s_done_v_o), 32'd0);

        // replicate size=7 with staggered ready
        push_hs(8, 16'h4407); push_hs(9, 16'h4407); push_hs(10, 16'h4407);
        r_done_q.push_back(8'h44);
        send_r(8'h44, 8'd7);
        chk("t4_v_o_t1", 32'(r_v_o), 32'h7);
        chk("t4_data1", 32'(r_data_o[1]), 32'h4407);
        r_ready_i = 3'b100;
        tick();
        chk("t4_v_o_t2", 32'(r_v_o), 32'h3);
        r_ready_i = 3'b000; r_done_v_i = 3'b100;
        tick();
        r_ready_i = 3'b001; r_done_v_i = 3'b000;
        tick();
        chk("t4_v_o_t4", 32'(r_v_o), 32'h2);
        r_ready_i = 3'b000; r_done_v_i = 3'b001;
        tick();
        r_ready_i = 3'b010; r_done_v_i = 3'b000;
        tick();
        chk("t4_v_o_t6", 32'(r_v_o), 32'h0);
        chk("t4_no_done_t6", 32'(r_done_v_o), 32'd0);
        r_ready_i = 3'b000; r_done_v_i = 3'b010;
        tick();
        r_done_v_i = 3'b000;
        chk("t4_done_t7", 32'(r_done_v_o), 32'd1);
        tick();
        chk("t4_ready_back", 32'(r_ready_o), 32'd1);

        // split size=4: done on out0 in its handshake cycle is ignored
        push_hs(0, 16'h5501); push_hs(1, 16'h5501); push_hs(2, 16'h5501); push_hs(3, 16'h5501);
        s_done_q.push_back(8'h55);
        send_s(8'h55, 8'd4);
        s_done_v_i = 4'b0001;
        tick();
        s_done_v_i = 4'b1110;
        tick();
        chk("t5_no_done", 32'(s_done_v_o), 32'd0);
        s_done_v_i = 4'b0001;
        tick();
        s_done_v_i = '0;
        chk("t5_done", 32'(s_done_v_o), 32'd1);
        tick();
        chk("t5_ready_back", 32'(s_ready_o), 32'd1);

        // reset in WAIT_DONE with outputs 2,3 outstanding
        push_hs(0, 16'h6603); push_hs(1, 16'h6603); push_hs(2, 16'h6602); push_hs(3, 16'h6602);
        send_s(8'h66, 8'd10);
        tick();
        s_done_v_i = 4'b0011;
        tick();
        s_done_v_i = '0;
        chk("t6_wait_ready", 32'(s_ready_o), 32'd0);
        chk("t6_wait_no_done", 32'(s_done_v_o), 32'd0);
        reset_i = 1'b1;
        tick();
        chk("t6_rst_ready", 32'(s_ready_o), 32'd1);
        chk("t6_rst_v_o", 32'(s_v_o), 32'h0);
        chk("t6_rst_done", 32'(s_done_v_o), 32'd0);
        reset_i = 1'b0;
        tick();
        tick();
        chk("t6_post_no_done", 32'(s_done_v_o), 32'd0);

        // fresh workload after reset: size=5 -> 2,1,1,1
        push_hs(0, 16'h7702); push_hs(1, 16'h7701); push_hs(2, 16'h7701); push_hs(3, 16'h7701);
        s_done_q.push_back(8'h77);
        send_s(8'h77, 8'd5);
        chk("t7_v_o", 32'(s_v_o), 32'hf);
        tick();
        s_done_v_i = 4'hf;
        tick();
        s_done_v_i = '0;
        chk("t7_done", 32'(s_done_v_o), 32'd1);
        tick();
        chk("t7_ready_back", 32'(s_ready_o), 32'd1);
        tick();

        chk("end_hs_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("end_s_done_queue_empty", 32'(s_done_q.size()), 32'd0);
        chk("end_r_done_queue_empty", 32'(r_done_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
